// File: rtl/io_handshake_peripheral.sv
// Byte source/sink partner for the Processor's four-phase ready/ACK I/O ports.
// Optional macro IO_PERIPH_IRQ_EN adds a registered "FIFO non-empty" irq output.
module io_handshake_peripheral #(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [7:0]                 tx_data,
   input  logic                       tx_valid,
   output logic                       tx_ready,
   output logic [$clog2(DEPTH+1)-1:0] tx_count,
   output logic [7:0]                 in,
   output logic                       inDataReady,
   input  logic                       inACK,
   input  logic [7:0]                 out,
   input  logic                       outDataReady,
   output logic                       outACK,
   output logic [7:0]                 rx_data,
   output logic                       rx_valid,
   input  logic                       rx_ready
`ifdef IO_PERIPH_IRQ_EN
   ,output logic                      irq
`endif
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
   localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

   typedef enum logic [1:0] {
      SRC_IDLE    = 2'd0,
      SRC_PRESENT = 2'd1,
      SRC_WAIT    = 2'd2
   } srcState_t;

   typedef enum logic {
      SNK_IDLE = 1'b0,
      SNK_ACK  = 1'b1
   } snkState_t;

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wrPtr_r, rdPtr_r;
   logic [CW-1:0] count_r;
   srcState_t     srcState_r, srcNext_s;
   snkState_t     snkState_r, snkNext_s;
   logic          push_s, srcPop_s, srcAck_s, snkCapture_s, snkRelease_s;

   // Readiness comes from the registered count only, so a same-cycle pop never frees a slot.
   assign tx_ready = (count_r != CNT_FULL);
   assign tx_count = count_r;
   assign push_s   = tx_valid && tx_ready;

   // FIFO storage write port
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wrPtr_r] <= tx_data;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wrPtr_r <= {AW{1'b0}};
         rdPtr_r <= {AW{1'b0}};
         count_r <= CNT_ZERO;
      end else begin
         if (push_s) begin
            wrPtr_r <= wrPtr_r + PTR_ONE;
         end
         if (srcPop_s) begin
            rdPtr_r <= rdPtr_r + PTR_ONE;
         end
         case ({push_s, srcPop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Source FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         srcState_r <= SRC_IDLE;
      end else begin
         srcState_r <= srcNext_s;
      end
   end

   // Source FSM next-state and pop/ack decisions
   always_comb begin
      srcNext_s = srcState_r;
      srcPop_s  = 1'b0;
      srcAck_s  = 1'b0;
      case (srcState_r)
         SRC_IDLE: begin
            if (count_r != CNT_ZERO) begin
               srcNext_s = SRC_PRESENT;
               srcPop_s  = 1'b1;
            end else begin
               srcNext_s = SRC_IDLE;
            end
         end
         SRC_PRESENT: begin
            if (inACK) begin
               srcNext_s = SRC_WAIT;
               srcAck_s  = 1'b1;
            end else begin
               srcNext_s = SRC_PRESENT;
            end
         end
         SRC_WAIT: begin
            if (!inACK) begin
               srcNext_s = SRC_IDLE;
            end else begin
               srcNext_s = SRC_WAIT;
            end
         end
         default: srcNext_s = SRC_IDLE;
      endcase
   end

   // Source-side registered outputs; 'in' holds its value between transfers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         in          <= 8'h00;
         inDataReady <= 1'b0;
      end else if (srcPop_s) begin
         in          <= mem_r[rdPtr_r];
         inDataReady <= 1'b1;
      end else if (srcAck_s) begin
         inDataReady <= 1'b0;
      end
   end

   // Sink FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snkState_r <= SNK_IDLE;
      end else begin
         snkState_r <= snkNext_s;
      end
   end

   // Sink FSM: capture only from IDLE, so a held outDataReady cannot re-capture
   always_comb begin
      snkNext_s    = snkState_r;
      snkCapture_s = 1'b0;
      snkRelease_s = 1'b0;
      case (snkState_r)
         SNK_IDLE: begin
            if (outDataReady && rx_ready) begin
               snkNext_s    = SNK_ACK;
               snkCapture_s = 1'b1;
            end else begin
               snkNext_s = SNK_IDLE;
            end
         end
         SNK_ACK: begin
            if (!outDataReady) begin
               snkNext_s    = SNK_IDLE;
               snkRelease_s = 1'b1;
            end else begin
               snkNext_s = SNK_ACK;
            end
         end
         default: snkNext_s = SNK_IDLE;
      endcase
   end

   // Sink-side registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         outACK   <= 1'b0;
      end else begin
         rx_valid <= snkCapture_s;
         if (snkCapture_s) begin
            rx_data <= out;
            outACK  <= 1'b1;
         end else if (snkRelease_s) begin
            outACK  <= 1'b0;
         end
      end
   end

`ifdef IO_PERIPH_IRQ_EN
   // Interrupt mirrors FIFO non-empty, one cycle behind the count
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irq <= 1'b0;
      end else begin
         irq <= (count_r != CNT_ZERO);
      end
   end
`endif

endmodule
